// File: rtl/au_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : au_issue_arbiter
// Brief    : Valid/ready arbiter sharing one AU between NUM_REQ requesters,
//            with a single issue register and an ID-tagged held response.
//            Define AU_ARB_FIXED_PRIO_EN for lowest-index fixed priority
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module au_issue_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*4-1:0]    req_aluop,
   input  logic [NUM_REQ*32-1:0]   req_port_a,
   input  logic [NUM_REQ*32-1:0]   req_port_b,
   input  logic [NUM_REQ-1:0]      req_wen,
   output logic [3:0]              au_aluop,
   output logic [31:0]             au_port_a,
   output logic [31:0]             au_port_b,
   output logic                    au_wen,
   input  logic [31:0]             au_wdata,
   input  logic                    au_wen_au,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_wdata,
   output logic                    rsp_wen,
   output logic                    busy
);

   logic                  issue_valid_q, issue_valid_d;
   logic [ID_W-1:0]       issue_id_q,    issue_id_d;
   logic [3:0]            issue_aluop_q, issue_aluop_d;
   logic [31:0]           issue_a_q,     issue_a_d;
   logic [31:0]           issue_b_q,     issue_b_d;
   logic                  issue_wen_q,   issue_wen_d;

   logic                  can_accept;
   logic                  transfer;
   logic [NUM_REQ-1:0]    grant_oh;
   logic [ID_W-1:0]       grant_id;

   // OR-chains turning the one-hot grant into the winner's id and fields
   logic [ID_W-1:0]       enc_id    [NUM_REQ+1];
   logic [3:0]            enc_aluop [NUM_REQ+1];
   logic [31:0]           enc_a     [NUM_REQ+1];
   logic [31:0]           enc_b     [NUM_REQ+1];
   logic [NUM_REQ:0]      enc_wen;

   assign enc_id[0]    = '0;
   assign enc_aluop[0] = '0;
   assign enc_a[0]     = '0;
   assign enc_b[0]     = '0;
   assign enc_wen[0]   = 1'b0;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign enc_id[gi+1]    = enc_id[gi]    | (grant_oh[gi] ? ID_W'(gi) : '0);
      assign enc_aluop[gi+1] = enc_aluop[gi] | ({4{grant_oh[gi]}}  & req_aluop[gi*4 +: 4]);
      assign enc_a[gi+1]     = enc_a[gi]     | ({32{grant_oh[gi]}} & req_port_a[gi*32 +: 32]);
      assign enc_b[gi+1]     = enc_b[gi]     | ({32{grant_oh[gi]}} & req_port_b[gi*32 +: 32]);
      assign enc_wen[gi+1]   = enc_wen[gi]   | (grant_oh[gi] & req_wen[gi]);
   end

   assign grant_id = enc_id[NUM_REQ];

`ifdef AU_ARB_FIXED_PRIO_EN
   assign grant_oh = req_valid & (~req_valid + NUM_REQ'(1));
`else
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]    above_ptr;
   logic [NUM_REQ-1:0]    upper_valid;

   // Requesters strictly above the pointer get first pick; otherwise wrap to the lowest.
   assign above_ptr   = ~((NUM_REQ'(2) << rr_ptr_q) - NUM_REQ'(1));
   assign upper_valid = req_valid & above_ptr;
   assign grant_oh    = (upper_valid != '0) ? (upper_valid & (~upper_valid + NUM_REQ'(1)))
                                            : (req_valid   & (~req_valid   + NUM_REQ'(1)));

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (transfer) begin
         rr_ptr_d = grant_id;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   assign can_accept = !issue_valid_q || rsp_ready;
   assign transfer   = can_accept && (req_valid != '0);
   assign req_ready  = can_accept ? grant_oh : '0;

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_id_d    = issue_id_q;
      issue_aluop_d = issue_aluop_q;
      issue_a_d     = issue_a_q;
      issue_b_d     = issue_b_q;
      issue_wen_d   = issue_wen_q;
      if (transfer) begin
         issue_valid_d = 1'b1;
         issue_id_d    = grant_id;
         issue_aluop_d = enc_aluop[NUM_REQ];
         issue_a_d     = enc_a[NUM_REQ];
         issue_b_d     = enc_b[NUM_REQ];
         issue_wen_d   = enc_wen[NUM_REQ];
      end else if (rsp_ready) begin
         issue_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         issue_valid_q <= 1'b0;
         issue_id_q    <= '0;
         issue_aluop_q <= '0;
         issue_a_q     <= '0;
         issue_b_q     <= '0;
         issue_wen_q   <= 1'b0;
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_id_q    <= issue_id_d;
         issue_aluop_q <= issue_aluop_d;
         issue_a_q     <= issue_a_d;
         issue_b_q     <= issue_b_d;
         issue_wen_q   <= issue_wen_d;
      end
   end

   // Stale fields stay in the register after a response; gate them off the AU.
   assign au_aluop  = issue_valid_q ? issue_aluop_q : 4'd0;
   assign au_port_a = issue_valid_q ? issue_a_q     : 32'd0;
   assign au_port_b = issue_valid_q ? issue_b_q     : 32'd0;
   assign au_wen    = issue_valid_q & issue_wen_q;

   assign rsp_valid = issue_valid_q;
   assign rsp_id    = issue_id_q;
   assign rsp_wdata = issue_valid_q ? au_wdata : 32'd0;
   assign rsp_wen   = issue_valid_q & au_wen_au;
   assign busy      = issue_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_au_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_au_issue_arbiter
// Brief    : Self-checking bench for au_issue_arbiter: directed vector table,
//            reset sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_au_issue_arbiter;
   localparam int NUM_REQ = 2;
   localparam int ID_W    = 3;

   logic                   CLK = 1'b0;
   logic                   RST;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*4-1:0]   req_aluop;
   logic [NUM_REQ*32-1:0]  req_port_a;
   logic [NUM_REQ*32-1:0]  req_port_b;
   logic [NUM_REQ-1:0]     req_wen;
   logic [3:0]             au_aluop;
   logic [31:0]            au_port_a;
   logic [31:0]            au_port_b;
   logic                   au_wen;
   logic [31:0]            au_wdata;
   logic                   au_wen_au;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [31:0]            rsp_wdata;
   logic                   rsp_wen;
   logic                   busy;

   int n_total = 0;
   int n_pass  = 0;

   always #5 CLK = ~CLK;

   au_issue_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_aluop  (req_aluop),
      .req_port_a (req_port_a),
      .req_port_b (req_port_b),
      .req_wen    (req_wen),
      .au_aluop   (au_aluop),
      .au_port_a  (au_port_a),
      .au_port_b  (au_port_b),
      .au_wen     (au_wen),
      .au_wdata   (au_wdata),
      .au_wen_au  (au_wen_au),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_wdata  (rsp_wdata),
      .rsp_wen    (rsp_wen),
      .busy       (busy)
   );

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   // Combinational AU stand-in
   assign au_wdata  = alu(au_aluop, au_port_a, au_port_b);
   assign au_wen_au = au_wen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Reference model: one pending op slot plus the last winner
   bit          m_valid;
   int          m_id;
   int          m_ptr;
   logic [3:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;
   bit          m_wen;

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_ptr = NUM_REQ - 1;
      m_op = '0; m_a = '0; m_b = '0; m_wen = 0;
   endtask

   function automatic int m_winner();
`ifdef AU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i]) return i;
`else
      for (int k = 1; k <= NUM_REQ; k++) begin
         int i;
         i = (m_ptr + k) % NUM_REQ;
         if (req_valid[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic check_model(input string tag);
      int w;
      bit can;
      logic [NUM_REQ-1:0] er;
      can = !m_valid || rsp_ready;
      w   = m_winner();
      er  = '0;
      if (can && w >= 0) er[w] = 1'b1;
      chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'(er));
      chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(m_valid));
      chk($sformatf("%s.busy", tag),      32'(busy),      32'(m_valid));
      chk($sformatf("%s.rsp_id", tag),    32'(rsp_id),    32'(m_id));
      chk($sformatf("%s.rsp_wdata", tag), rsp_wdata,      m_valid ? alu(m_op, m_a, m_b) : 32'd0);
      chk($sformatf("%s.rsp_wen", tag),   32'(rsp_wen),   32'(m_valid && m_wen));
      chk($sformatf("%s.au_aluop", tag),  32'(au_aluop),  m_valid ? 32'(m_op) : 32'd0);
      chk($sformatf("%s.au_port_a", tag), au_port_a,      m_valid ? m_a : 32'd0);
      chk($sformatf("%s.au_port_b", tag), au_port_b,      m_valid ? m_b : 32'd0);
      chk($sformatf("%s.au_wen", tag),    32'(au_wen),    32'(m_valid && m_wen));
   endtask

   task automatic model_step();
      int w;
      bit can;
      can = !m_valid || rsp_ready;
      w   = m_winner();
      if (can && w >= 0) begin
         m_valid = 1;
         m_id    = w;
         m_op    = req_aluop[w*4 +: 4];
         m_a     = req_port_a[w*32 +: 32];
         m_b     = req_port_b[w*32 +: 32];
         m_wen   = req_wen[w];
`ifndef AU_ARB_FIXED_PRIO_EN
         m_ptr   = w;
`endif
      end else if (rsp_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic tick(input string tag);
      @(negedge CLK);
      check_model(tag);
      model_step();
      @(posedge CLK);
      #1;
   endtask

   // Mid-cycle asynchronous reset; outputs must drop before any clock edge
   task automatic do_reset(input string tag);
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'd0);
      chk($sformatf("%s.busy", tag),      32'(busy),      32'd0);
      chk($sformatf("%s.rsp_id", tag),    32'(rsp_id),    32'd0);
      chk($sformatf("%s.rsp_wdata", tag), rsp_wdata,      32'd0);
      chk($sformatf("%s.rsp_wen", tag),   32'(rsp_wen),   32'd0);
      chk($sformatf("%s.au_aluop", tag),  32'(au_aluop),  32'd0);
      chk($sformatf("%s.au_port_a", tag), au_port_a,      32'd0);
      chk($sformatf("%s.au_port_b", tag), au_port_b,      32'd0);
      chk($sformatf("%s.au_wen", tag),    32'(au_wen),    32'd0);
      chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd0);
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic        rdy;
      logic [1:0]  exp_ready;
      logic        exp_rv;
      logic [2:0]  exp_id;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t tbl[$];

   initial begin
      RST        = 1'b1;
      req_valid  = '0;
      req_aluop  = '0;
      req_port_a = '0;
      req_port_b = '0;
      req_wen    = '0;
      rsp_ready  = 1'b0;
      model_reset();

      // req0: ADD 5+7=12, req1: SUB 20-3=17
`ifdef AU_ARB_FIXED_PRIO_EN
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 3'd0, 32'd0});
`else
      tbl.push_back('{2'b01, 1'b1, 2'b01, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b11, 1'b1, 2'b10, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b11, 1'b1, 2'b10, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b11, 1'b1, 2'b10, 1'b0, 3'd0, 32'd0});
      tbl.push_back('{2'b11, 1'b0, 2'b00, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b11, 1'b0, 2'b00, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b11, 1'b0, 2'b00, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b11, 1'b1, 2'b01, 1'b1, 3'd1, 32'd17});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b1, 3'd0, 32'd12});
      tbl.push_back('{2'b00, 1'b1, 2'b00, 1'b0, 3'd0, 32'd0});
`endif

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      do_reset("rst_mid");

      req_aluop[0 +: 4]   = 4'd0;  req_port_a[0 +: 32]  = 32'd5;  req_port_b[0 +: 32]  = 32'd7; req_wen[0] = 1'b1;
      req_aluop[4 +: 4]   = 4'd1;  req_port_a[32 +: 32] = 32'd20; req_port_b[32 +: 32] = 32'd3; req_wen[1] = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         req_valid = tbl[i].valid;
         rsp_ready = tbl[i].rdy;
         @(negedge CLK);
         chk($sformatf("tbl%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d.rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_rv));
         chk($sformatf("tbl%0d.rsp_id", i),    32'(rsp_id),    32'(tbl[i].exp_id));
         chk($sformatf("tbl%0d.rsp_wdata", i), rsp_wdata,      tbl[i].exp_wdata);
         check_model($sformatf("tbl%0d", i));
         model_step();
         @(posedge CLK);
         #1;
      end

      // Reset while a response is stalled, then req0 must win first
      req_valid = 2'b10; rsp_ready = 1'b1;
      tick("inflight_issue");
      req_valid = 2'b00; rsp_ready = 1'b0;
      tick("inflight_stall");
      do_reset("rst_inflight");
      req_valid = 2'b11; rsp_ready = 1'b1;
      @(negedge CLK);
      chk("post_rst.req_ready", 32'(req_ready), 32'd1);
      check_model("post_rst");
      model_step();
      @(posedge CLK);
      #1;

      for (int c = 0; c < 400; c++) begin
         req_valid = NUM_REQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < NUM_REQ; r++) begin
            req_aluop[r*4 +: 4]    = 4'($urandom_range(0, 7));
            req_port_a[r*32 +: 32] = $urandom;
            req_port_b[r*32 +: 32] = $urandom;
            req_wen[r]             = 1'($urandom);
         end
         tick($sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/au_issue_arbiter.md
Name: au_issue_arbiter

Overview:
- Shares one arithmetic unit (AU) execute datapath between NUM_REQ requesters, e.g. the main pipeline ALU slot and the CSR read-modify-write path.
- Round-robin arbitration with valid/ready handshakes on both sides.
- One issue register drives the AU; a held response port returns the AU result tagged with the requester ID.
- Sits in execute, between requester pipelines and the AU.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high.
- req_aluop  input  NUM_REQ*4  per-requester aluop_t; slice i belongs to requester i.
- req_port_a  input  NUM_REQ*32  per-requester operand A.
- req_port_b  input  NUM_REQ*32  per-requester operand B.
- req_wen  input  NUM_REQ  per-requester write enable.
- au_aluop  output  4  to AU aluop.
- au_port_a  output  32  to AU port_a.
- au_port_b  output  32  to AU port_b.
- au_wen  output  1  to AU wen; already gated by issue valid.
- au_wdata  input  32  AU wdata_au.
- au_wen_au  input  1  AU wen_au.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  ID of the requester that owns the response.
- rsp_wdata  output  32  result.
- rsp_wen  output  1  result write enable.
- busy  output  1  issue register occupied.

Behaviour:
- Reset values:
  - issue_valid=0; rsp_valid=0; busy=0; rsp_id=0; rsp_wdata=0; rsp_wen=0.
  - au_aluop, au_port_a, au_port_b and au_wen are 0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation discards the in-flight op; no response is produced for it.
- The issue register holds {valid, id, aluop, a, b, wen}.
- The AU is combinational. While the register is valid:
  - rsp_wdata = au_wdata.
  - rsp_wen = au_wen_au.
  - rsp_valid = issue_valid.
- When issue_valid=0, the AU inputs and au_wen are forced to 0.
- can_accept = !issue_valid | rsp_ready.
- Arbitration:
  - Search requesters starting at (rr_ptr+1) mod NUM_REQ, wrapping around.
  - The first requester with valid high wins.
  - Exactly one req_ready is high, and only for the winner, and only when can_accept=1.
  - All other req_ready bits are 0.
  - req_ready never depends on rsp_valid except through can_accept.
- On a transfer:
  - The issue register loads the winner's fields.
  - issue_valid=1 and id=winner.
  - rr_ptr=winner.
- rr_ptr changes only on a transfer.
- Response handshake:
  - If rsp_ready is high while issue_valid is high and there is no new transfer, issue_valid clears next cycle.
  - If rsp_ready is high and a new transfer happens in the same cycle, the register reloads. This gives back-to-back throughput of 1 op per cycle.
- Latency: a request accepted in cycle N produces rsp_valid in cycle N+1.
- Stall: while rsp_valid=1 and rsp_ready=0:
  - The issue register, rsp_id, and the AU inputs hold stable.
  - All req_ready bits are 0.
- No requests while idle: issue_valid stays 0 and rr_ptr is unchanged.
- A requester that drops valid before being granted is simply skipped.
- busy = issue_valid.

Optional Feature:
- Macro: AU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins. rr_ptr is not implemented and is not updated.
- Undefined: round-robin as described above.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset, then single request: assert RST mid-cycle; check all outputs 0. Then req0 valid with aluop ADD, a=5, b=7, wen=1. Required: req_ready[0]=1 in cycle N; in cycle N+1 rsp_valid=1, rsp_id=0, rsp_wdata=12, rsp_wen=1.
- Round-robin: req0 and req1 held valid continuously, rsp_ready=1. Required grants alternate 0,1,0,1; responses arrive every cycle; rsp_id sequence is 0,1,0,1.
- Back-pressure: one op issued, rsp_ready=0 for 3 cycles. Required: rsp_valid, rsp_id, rsp_wdata and au_port_a/b hold stable; req_ready=0. When rsp_ready rises, the next request is accepted in the same cycle.
- Idle gap: issue one op, drop all valids for 2 cycles. Required: rsp_valid falls after the handshake; au_wen=0; rr_ptr is preserved, so the next simultaneous request goes to the other requester.
- Reset in flight: assert RST while rsp_valid=1 and rsp_ready=0. Required: rsp_valid=0 immediately (asynchronous); after release, req0 wins first.
- Fixed priority (build with AU_ARB_FIXED_PRIO_EN): both requesters valid for 4 cycles. Required: all 4 grants go to req0 and req1 is never ready.
